// File: rtl/x_delay_line_meas.sv
`default_nettype none
// ============================================================================
//  Module      : x_delay_line_meas
//  Description : Edge-position measurement for a tapped delay line. Decodes
//                each tap snapshot into the length of the run of taps from
//                tap 0 that match tap 0, accumulates 2^LOG2_AVG positions per
//                window into sum/min/max/avg plus a saturation flag, and
//                presents the window result on a valid/ready handshake.
//  Ports       : i_clk, i_rst_n (async, active low)
//                i_data[WIDTH]  tap snapshot (bit 0 = launch tap)
//                i_en           snapshot accept enable
//                i_clear        synchronous abort/clear
//                o_valid/i_ready result handshake
//                o_pos          last decoded position
//                o_min/o_max/o_sum/o_avg/o_sat  window result
//                o_drop         sticky: snapshot arrived while result pending
//  Revision    : 1.0 - initial release
// ============================================================================
module x_delay_line_meas #(
    parameter  int WIDTH    = 32,
    parameter  int LOG2_AVG = 4,
    localparam int PW       = $clog2(WIDTH) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_en,
    input  logic                   i_clear,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [PW-1:0]          o_pos,
    output logic [PW-1:0]          o_min,
    output logic [PW-1:0]          o_max,
    output logic [PW+LOG2_AVG-1:0] o_sum,
    output logic [PW-1:0]          o_avg,
    output logic                   o_sat,
    output logic                   o_drop
);

    localparam int SW = PW + LOG2_AVG;
    localparam int CW = LOG2_AVG + 1;
    // Count value held just before the sample that completes a window
    localparam logic [CW-1:0] c_LAST = CW'((1 << LOG2_AVG) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Decode: run length from tap 0. Only the first mismatch matters, so
    // bubbles further up the line are ignored.
    // ------------------------------------------------------------------
    logic [PW-1:0] w_pos;
    logic          w_found;

    always_comb begin
        w_pos   = PW'(WIDTH);
        w_found = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            if (!w_found && (i_data[i] != i_data[0])) begin
                w_pos   = PW'(i);
                w_found = 1'b1;
            end
        end
    end

    logic [PW-1:0] r_pos_q;
    logic          r_dv_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos_q <= '0;
            r_dv_q  <= 1'b0;
        end else if (i_clear) begin
            r_pos_q <= '0;
            r_dv_q  <= 1'b0;
        end else begin
            r_dv_q <= i_en;
            if (i_en) begin
                r_pos_q <= w_pos;
            end
        end
    end

    assign o_pos = r_pos_q;

    // ------------------------------------------------------------------
    // Window accumulation and result FSM
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [SW-1:0] r_sum;
    logic [PW-1:0] r_min;
    logic [PW-1:0] r_max;
    logic [CW-1:0] r_cnt;
    logic          r_sat_acc;

    logic [PW-1:0] r_out_min;
    logic [PW-1:0] r_out_max;
    logic [SW-1:0] r_out_sum;
    logic [PW-1:0] r_out_avg;
    logic          r_out_sat;
    logic          r_valid;
    logic          r_drop;

    logic [SW-1:0] w_sum_nxt;
    logic [PW-1:0] w_min_nxt;
    logic [PW-1:0] w_max_nxt;
    logic          w_is_sat;

    assign w_sum_nxt = r_sum + SW'(r_pos_q);
    assign w_min_nxt = (r_pos_q < r_min) ? r_pos_q : r_min;
    assign w_max_nxt = (r_pos_q > r_max) ? r_pos_q : r_max;
    assign w_is_sat  = (r_pos_q == PW'(WIDTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_sum     <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_cnt     <= '0;
            r_sat_acc <= 1'b0;
            r_out_min <= '0;
            r_out_max <= '0;
            r_out_sum <= '0;
            r_out_avg <= '0;
            r_out_sat <= 1'b0;
            r_valid   <= 1'b0;
            r_drop    <= 1'b0;
        end else if (i_clear) begin
            r_state   <= S_IDLE;
            r_sum     <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_cnt     <= '0;
            r_sat_acc <= 1'b0;
            r_out_min <= '0;
            r_out_max <= '0;
            r_out_sum <= '0;
            r_out_avg <= '0;
            r_out_sat <= 1'b0;
            r_valid   <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // First sample of the window seeds the accumulators
                    if (r_dv_q) begin
                        r_sum     <= SW'(r_pos_q);
                        r_min     <= r_pos_q;
                        r_max     <= r_pos_q;
                        r_cnt     <= CW'(1);
                        r_sat_acc <= w_is_sat;
                        r_state   <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (r_dv_q) begin
                        r_sum     <= w_sum_nxt;
                        r_min     <= w_min_nxt;
                        r_max     <= w_max_nxt;
                        r_cnt     <= r_cnt + CW'(1);
                        r_sat_acc <= r_sat_acc | w_is_sat;
                        if (r_cnt == c_LAST) begin
                            r_out_sum <= w_sum_nxt;
                            r_out_min <= w_min_nxt;
                            r_out_max <= w_max_nxt;
                            r_out_avg <= w_sum_nxt[SW-1:LOG2_AVG];
                            r_out_sat <= r_sat_acc | w_is_sat;
                            r_valid   <= 1'b1;
                            r_state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Samples arriving while a result is pending are lost,
                    // including one coinciding with the handshake.
                    if (r_dv_q) begin
                        r_drop <= 1'b1;
                    end
                    if (i_ready) begin
                        r_valid   <= 1'b0;
                        r_state   <= S_IDLE;
                        r_sum     <= '0;
                        r_min     <= '0;
                        r_max     <= '0;
                        r_cnt     <= '0;
                        r_sat_acc <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_min   = r_out_min;
    assign o_max   = r_out_max;
    assign o_sum   = r_out_sum;
    assign o_avg   = r_out_avg;
    assign o_sat   = r_out_sat;
    assign o_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_x_delay_line_meas.sv
`default_nettype none
// ============================================================================
//  Module      : tb_x_delay_line_meas
//  Description : Directed self-checking bench for x_delay_line_meas.
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_x_delay_line_meas;

    localparam int WIDTH    = 32;
    localparam int LOG2_AVG = 4;
    localparam int PW       = 6;
    localparam int SW       = PW + LOG2_AVG;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WIDTH-1:0]  data;
    logic              en;
    logic              clear;
    logic              ready;
    logic              o_valid;
    logic [PW-1:0]     o_pos;
    logic [PW-1:0]     o_min;
    logic [PW-1:0]     o_max;
    logic [SW-1:0]     o_sum;
    logic [PW-1:0]     o_avg;
    logic              o_sat;
    logic              o_drop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    x_delay_line_meas #(.WIDTH(WIDTH), .LOG2_AVG(LOG2_AVG)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (data),
        .i_en    (en),
        .i_clear (clear),
        .o_valid (o_valid),
        .i_ready (ready),
        .o_pos   (o_pos),
        .o_min   (o_min),
        .o_max   (o_max),
        .o_sum   (o_sum),
        .o_avg   (o_avg),
        .o_sat   (o_sat),
        .o_drop  (o_drop)
    );

    task automatic send(input logic [WIDTH-1:0] d);
        data = d;
        en   = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic handshake;
        en    = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; clear = 1'b0; ready = 1'b0; data = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d want 0", o_valid); end
        n_tests++; if (o_pos !== 0 || o_min !== 0 || o_max !== 0) begin n_fail++; $display("FAIL reset_pos_min_max: got %0d/%0d/%0d want 0/0/0", o_pos, o_min, o_max); end
        n_tests++; if (o_sum !== 0 || o_avg !== 0) begin n_fail++; $display("FAIL reset_sum_avg: got %0d/%0d want 0/0", o_sum, o_avg); end
        n_tests++; if (o_sat !== 1'b0 || o_drop !== 1'b0) begin n_fail++; $display("FAIL reset_sat_drop: got %0d/%0d want 0/0", o_sat, o_drop); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        for (int i = 0; i < 16; i++) send(32'h0000_00FF);
        // Last sample is only in the decode register here
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0d want 0", o_valid); end
        idle(1);
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid: got %0d want 1", o_valid); end
        n_tests++; if (o_min !== 8 || o_max !== 8) begin n_fail++; $display("FAIL basic_min_max: got %0d/%0d want 8/8", o_min, o_max); end
        n_tests++; if (o_sum !== 128) begin n_fail++; $display("FAIL basic_sum: got %0d want 128", o_sum); end
        n_tests++; if (o_avg !== 8) begin n_fail++; $display("FAIL basic_avg: got %0d want 8", o_avg); end
        n_tests++; if (o_sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %0d want 0", o_sat); end
        n_tests++; if (o_pos !== 8) begin n_fail++; $display("FAIL basic_pos: got %0d want 8", o_pos); end
        handshake;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after_hs: got %0d want 0", o_valid); end
        n_tests++; if (o_sum !== 128) begin n_fail++; $display("FAIL basic_sum_held: got %0d want 128", o_sum); end
    endtask

    task automatic test_alternate;
        bit ok;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1)      send(32'h0000_0001);
            else if (i % 4 == 0) send(32'h0000_000F);
            else                 send(32'hFFFF_FFF0);
        end
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL alt_timeout: got valid=%0d want 1", o_valid); end
        n_tests++; if (o_min !== 1 || o_max !== 4) begin n_fail++; $display("FAIL alt_min_max: got %0d/%0d want 1/4", o_min, o_max); end
        n_tests++; if (o_sum !== 40 || o_avg !== 2) begin n_fail++; $display("FAIL alt_sum_avg: got %0d/%0d want 40/2", o_sum, o_avg); end
        n_tests++; if (o_sat !== 1'b0) begin n_fail++; $display("FAIL alt_sat: got %0d want 0", o_sat); end
        handshake;
    endtask

    task automatic test_sat;
        bit ok;
        send(32'hFFFF_FFFF);
        n_tests++; if (o_pos !== 32) begin n_fail++; $display("FAIL sat_pos_full: got %0d want 32", o_pos); end
        send(32'h0000_00F7);
        n_tests++; if (o_pos !== 3) begin n_fail++; $display("FAIL sat_pos_bubble: got %0d want 3", o_pos); end
        for (int i = 0; i < 14; i++) send(32'h0000_00FF);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL sat_timeout: got valid=%0d want 1", o_valid); end
        n_tests++; if (o_sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %0d want 1", o_sat); end
        n_tests++; if (o_min !== 3 || o_max !== 32) begin n_fail++; $display("FAIL sat_min_max: got %0d/%0d want 3/32", o_min, o_max); end
        n_tests++; if (o_sum !== 147 || o_avg !== 9) begin n_fail++; $display("FAIL sat_sum_avg: got %0d/%0d want 147/9", o_sum, o_avg); end
        handshake;
    endtask

    task automatic test_hold;
        bit ok;
        n_tests++; if (o_drop !== 1'b0) begin n_fail++; $display("FAIL hold_drop_initial: got %0d want 0", o_drop); end
        for (int i = 0; i < 16; i++) send(32'h0000_0003);
        for (int i = 0; i < 10; i++) send(32'h0000_0001);
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %0d want 1", o_valid); end
        n_tests++; if (o_sum !== 32 || o_avg !== 2) begin n_fail++; $display("FAIL hold_sum_avg: got %0d/%0d want 32/2", o_sum, o_avg); end
        n_tests++; if (o_min !== 2 || o_max !== 2) begin n_fail++; $display("FAIL hold_min_max: got %0d/%0d want 2/2", o_min, o_max); end
        n_tests++; if (o_drop !== 1'b1) begin n_fail++; $display("FAIL hold_drop: got %0d want 1", o_drop); end
        n_tests++; if (o_pos !== 1) begin n_fail++; $display("FAIL hold_pos_live: got %0d want 1", o_pos); end
        handshake;
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid_after_hs: got %0d want 0", o_valid); end
        for (int i = 0; i < 16; i++) send(32'h0000_000F);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL hold_next_timeout: got valid=%0d want 1", o_valid); end
        n_tests++; if (o_sum !== 64 || o_min !== 4 || o_max !== 4 || o_avg !== 4) begin n_fail++; $display("FAIL hold_next_result: got sum=%0d min=%0d max=%0d avg=%0d want 64/4/4/4", o_sum, o_min, o_max, o_avg); end
        handshake;
    endtask

    task automatic test_en_gaps;
        bit ok;
        for (int i = 0; i < 16; i++) begin
            send(32'h0000_00FF);
            idle(1);
            if (i == 7) begin
                n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_mid_valid: got %0d want 0", o_valid); end
            end
        end
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL gaps_timeout: got valid=%0d want 1", o_valid); end
        n_tests++; if (o_sum !== 128 || o_min !== 8 || o_max !== 8 || o_avg !== 8) begin n_fail++; $display("FAIL gaps_result: got sum=%0d min=%0d max=%0d avg=%0d want 128/8/8/8", o_sum, o_min, o_max, o_avg); end
        n_tests++; if (o_drop !== 1'b1) begin n_fail++; $display("FAIL gaps_drop_sticky: got %0d want 1", o_drop); end
        handshake;
    endtask

    task automatic test_clear_reset;
        bit ok;
        for (int i = 0; i < 7; i++) send(32'h0000_0001);
        clear = 1'b1;
        send(32'h0000_00FF);
        clear = 1'b0;
        en    = 1'b0;
        n_tests++; if (o_valid !== 1'b0 || o_sat !== 1'b0 || o_drop !== 1'b0) begin n_fail++; $display("FAIL clear_flags: got valid=%0d sat=%0d drop=%0d want 0/0/0", o_valid, o_sat, o_drop); end
        n_tests++; if (o_sum !== 0 || o_min !== 0 || o_max !== 0 || o_avg !== 0) begin n_fail++; $display("FAIL clear_results: got sum=%0d min=%0d max=%0d avg=%0d want 0", o_sum, o_min, o_max, o_avg); end
        n_tests++; if (o_pos !== 0) begin n_fail++; $display("FAIL clear_pos: got %0d want 0", o_pos); end
        idle(2);
        n_tests++; if (o_pos !== 0) begin n_fail++; $display("FAIL clear_discard: got pos=%0d want 0", o_pos); end
        for (int i = 0; i < 16; i++) send(32'h0000_0007);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL clear_next_timeout: got valid=%0d want 1", o_valid); end
        n_tests++; if (o_sum !== 48 || o_min !== 3 || o_max !== 3 || o_avg !== 3) begin n_fail++; $display("FAIL clear_next_result: got sum=%0d min=%0d max=%0d avg=%0d want 48/3/3/3", o_sum, o_min, o_max, o_avg); end
        // Asynchronous reset while the result is held, away from any edge
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (o_valid !== 1'b0 || o_sum !== 0 || o_min !== 0 || o_pos !== 0) begin n_fail++; $display("FAIL async_reset: got valid=%0d sum=%0d min=%0d pos=%0d want 0", o_valid, o_sum, o_min, o_pos); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) send(32'h0000_001F);
        wait_valid(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL reset_next_timeout: got valid=%0d want 1", o_valid); end
        n_tests++; if (o_sum !== 80 || o_min !== 5 || o_max !== 5 || o_avg !== 5 || o_sat !== 1'b0) begin n_fail++; $display("FAIL reset_next_result: got sum=%0d min=%0d max=%0d avg=%0d sat=%0d want 80/5/5/5/0", o_sum, o_min, o_max, o_avg, o_sat); end
        handshake;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_alternate;
        test_sat;
        test_hold;
        test_en_gaps;
        test_clear_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
